// File: rtl/nes_io_pkg.sv
// Shared NES I/O constants: controller button bit order, joypad register
// addresses and the open-bus value returned on the undriven data bits.
package nes_io_pkg;

  // Serial order of the standard controller: bit0 is shifted out first
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [15:0] JOY0_ADDR        = 16'h4016;
  localparam logic [15:0] JOY1_ADDR        = 16'h4017;
  localparam logic [7:0]  OPEN_BUS_DEFAULT = 8'h40;

  // A joypad read drives only D0; everything above it floats to open bus.
  function automatic logic [7:0] joy_read_byte(input logic [7:0] open_bus,
                                               input logic       serial_bit);
    return open_bus | {7'b0, serial_bit};
  endfunction

endpackage

// File: rtl/cpu6502_joypad_port_if.sv
// CPU-side register bus between the 6502 core and the joypad responder.
interface cpu6502_joypad_port_if;

  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        we;
  logic        re;
  logic [7:0]  data_out;
  logic        rd_valid;

  modport master (
    output addr, data_in, we, re,
    input  data_out, rd_valid
  );

  modport slave (
    input  addr, data_in, we, re,
    output data_out, rd_valid
  );

endinterface

// File: rtl/joypad_debounce.sv
// Two-flop synchroniser followed by a per-bit stability counter; a bit is
// accepted only after it has differed from the accepted value for CYCLES clocks.
module joypad_debounce #(
  parameter int WIDTH  = 8,
  parameter int CYCLES = 50000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] state
);

  localparam int             CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CYCLES - 1);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [CW-1:0]    cnt [WIDTH];

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; a blocking '=' would collapse the
  // two synchroniser stages into one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_meta <= '0;
      sync_q    <= '0;
      state     <= '0;
      // NOTE: the counter array is small flop storage, not a RAM, so it is
      // cleared explicitly; a RAM-style array would be left unreset.
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == state[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          state[i] <= sync_q[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cpu6502_joypad_port.sv
// $4016/$4017 controller ports: strobe latch, serial shift registers and the
// registered read path onto the CPU data bus.
module cpu6502_joypad_port
  import nes_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR       = JOY0_ADDR,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [7:0]  OPEN_BUS        = OPEN_BUS_DEFAULT
) (
  input  logic                        CLK,
  input  logic                        RESET,
  cpu6502_joypad_port_if.slave        bus,
  input  logic [7:0]                  pad0_raw,
  input  logic [7:0]                  pad1_raw
);

  logic [7:0] pad0;
  logic [7:0] pad1;
  logic [7:0] shift0;
  logic [7:0] shift1;
  logic       strobe;
  logic       hit0;
  logic       hit1;
  logic       rd_hit;
  logic       rd_bit;
  logic [7:0] data_q;
  logic       valid_q;

  joypad_debounce #(.WIDTH(8), .CYCLES(DEBOUNCE_CYCLES)) u_deb0 (
    .CLK   (CLK),
    .RESET (RESET),
    .raw   (pad0_raw),
    .state (pad0)
  );

  joypad_debounce #(.WIDTH(8), .CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
    .CLK   (CLK),
    .RESET (RESET),
    .raw   (pad1_raw),
    .state (pad1)
  );

  assign hit0   = (bus.addr == BASE_ADDR);
  assign hit1   = (bus.addr == BASE_ADDR + 16'd1);
  assign rd_hit = bus.re && (hit0 || hit1);

  // NOTE: rd_bit gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    rd_bit = 1'b0;
    if (hit0) begin
      rd_bit = shift0[BTN_A];
    end else if (hit1) begin
      rd_bit = shift1[BTN_A];
    end
  end

  // Reads sample the current strobe and shift contents; a write in the same
  // cycle only takes effect from the next edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      strobe  <= 1'b0;
      shift0  <= '0;
      shift1  <= '0;
    end else begin
      valid_q <= rd_hit;
      if (rd_hit) begin
        data_q <= joy_read_byte(OPEN_BUS, rd_bit);
      end

      if (bus.we && hit0) begin
        strobe <= bus.data_in[0];
      end

      // While strobe is high the shifters track the pads; the cycle that
      // clears strobe still has strobe=1, giving the final latch for free.
      if (strobe) begin
        shift0 <= pad0;
        shift1 <= pad1;
      end else begin
        if (bus.re && hit0) begin
          shift0 <= {1'b1, shift0[7:1]};
        end
        if (bus.re && hit1) begin
          shift1 <= {1'b1, shift1[7:1]};
        end
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.rd_valid = valid_q;

endmodule

// File: tb/tb_cpu6502_joypad_port.sv
// Scoreboard bench for the joypad port: reads push expected bytes, a negedge
// monitor pops them when rd_valid appears and checks value and latency.
module tb_cpu6502_joypad_port;

  logic       clk;
  logic       rst;
  logic [7:0] pad0_raw;
  logic [7:0] pad1_raw;

  cpu6502_joypad_port_if bus ();

  cpu6502_joypad_port #(
    .BASE_ADDR       (16'h4016),
    .DEBOUNCE_CYCLES (4),
    .OPEN_BUS        (8'h40)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .bus      (bus),
    .pad0_raw (pad0_raw),
    .pad1_raw (pad1_raw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;
  int   cyc;
  int   n_checks;
  int   n_errors;

  // Reference model of the port, kept at transaction level
  logic [7:0] model_pad   [2];
  logic [7:0] model_deb   [2];
  logic [7:0] model_shift [2];
  logic       model_strobe;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_rd_valid", 32'd1, 32'd0);
      end else begin
        mon_x = exp_q.pop_front();
        check(mon_x.tag, {24'd0, bus.data_out}, {24'd0, mon_x.data});
        check({mon_x.tag, "_lat"}, cyc - mon_x.cyc, 32'd1);
      end
    end
  end

  task automatic push_exp(input string tag, input logic [7:0] e);
    exp_t x;
    x.tag  = tag;
    x.data = e;
    x.cyc  = cyc;
    exp_q.push_back(x);
  endtask

  task automatic model_read(input int p, output logic [7:0] e);
    if (model_strobe) begin
      e = 8'h40 | {7'b0, model_deb[p][0]};
    end else begin
      e = 8'h40 | {7'b0, model_shift[p][0]};
      model_shift[p] = {1'b1, model_shift[p][7:1]};
    end
  endtask

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    if (a == 16'h4016) begin
      if (model_strobe && !d[0]) begin
        model_shift[0] = model_deb[0];
        model_shift[1] = model_deb[1];
      end
      model_strobe = d[0];
    end
  endtask

  task automatic bus_read(input int p, input string tag);
    logic [7:0] e;
    @(posedge clk); #1;
    bus.addr = 16'h4016 + 16'(p);
    bus.re   = 1'b1;
    model_read(p, e);
    push_exp(tag, e);
    @(posedge clk); #1;
    bus.re   = 1'b0;
    bus.addr = 16'h0000;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.addr    = a;
    bus.data_in = d;
    bus.we      = 1'b1;
    @(posedge clk); #1;
    bus.we   = 1'b0;
    bus.addr = 16'h0000;
    model_write(a, d);
  endtask

  // Read one port and write $4016 in the same cycle
  task automatic bus_read_write0(input int p, input logic [7:0] d, input string tag);
    logic [7:0] e;
    @(posedge clk); #1;
    bus.addr    = 16'h4016 + 16'(p);
    bus.re      = 1'b1;
    bus.we      = (p == 0);
    bus.data_in = d;
    model_read(p, e);
    push_exp(tag, e);
    if (p == 0) model_write(16'h4016, d);
    @(posedge clk); #1;
    bus.re   = 1'b0;
    bus.we   = 1'b0;
    bus.addr = 16'h0000;
  endtask

  task automatic latch();
    bus_write(16'h4016, 8'h01);
    bus_write(16'h4016, 8'h00);
  endtask

  task automatic set_pads(input logic [7:0] p0, input logic [7:0] p1);
    @(posedge clk); #1;
    pad0_raw = p0;
    pad1_raw = p1;
    model_pad[0] = p0;
    model_pad[1] = p1;
    repeat (10) @(posedge clk);
    #1;
    model_deb[0] = p0;
    model_deb[1] = p1;
  endtask

  task automatic do_reset(input logic with_read);
    @(posedge clk); #1;
    rst = 1'b1;
    if (with_read) begin
      bus.addr = 16'h4016;
      bus.re   = 1'b1;
    end
    @(posedge clk); #1;
    bus.re   = 1'b0;
    bus.addr = 16'h0000;
    @(posedge clk); #1;
    rst = 1'b0;
    model_strobe   = 1'b0;
    model_shift[0] = 8'h00;
    model_shift[1] = 8'h00;
    model_deb[0]   = 8'h00;
    model_deb[1]   = 8'h00;
    @(negedge clk);
    check("reset_data_out", {24'd0, bus.data_out}, 32'h0);
    check("reset_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    cyc          = 0;
    rst          = 1'b1;
    pad0_raw     = 8'h00;
    pad1_raw     = 8'h00;
    bus.addr     = 16'h0000;
    bus.data_in  = 8'h00;
    bus.we       = 1'b0;
    bus.re       = 1'b0;
    model_strobe = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_pad[i]   = 8'h00;
      model_deb[i]   = 8'h00;
      model_shift[i] = 8'h00;
    end

    // 1: power-on reset, then a read with strobe low returns open bus only
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("por_data_out", {24'd0, bus.data_out}, 32'h0);
    check("por_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_read(0, "t1_read");

    // 2: latch 1000_0101 and shift it out, then past the end
    set_pads(8'b1000_0101, 8'h00);
    latch();
    for (int i = 0; i < 10; i++) bus_read(0, $sformatf("t2_rd%0d", i));

    // 3: a 2-cycle glitch on pad1 A is rejected, a held press accepted
    @(posedge clk); #1;
    pad1_raw = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    pad1_raw = 8'h00;
    repeat (10) @(posedge clk);
    latch();
    bus_read(1, "t3_glitch");
    set_pads(model_pad[0], 8'h01);
    latch();
    bus_read(1, "t3_held");

    // 4: strobe held high returns A without shifting; B-only after release
    set_pads(8'h01, 8'h00);
    bus_write(16'h4016, 8'h01);
    for (int i = 0; i < 3; i++) bus_read(0, $sformatf("t4_strobe%0d", i));
    set_pads(8'h02, 8'h00);
    bus_write(16'h4016, 8'h00);
    bus_read(0, "t4_b0");
    bus_read(0, "t4_b1");

    // 5: the two ports shift independently
    set_pads(8'hFF, 8'h00);
    latch();
    for (int i = 0; i < 9; i++) begin
      bus_read(0, $sformatf("t5_p0_%0d", i));
      bus_read(1, $sformatf("t5_p1_%0d", i));
    end

    // 6: reset part way through a read sequence; the read during reset is dropped
    set_pads(8'h80, 8'h00);
    latch();
    for (int i = 0; i < 3; i++) bus_read(0, $sformatf("t6_pre%0d", i));
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) bus_read(0, $sformatf("t6_post%0d", i));

    // Writes to $4017 must not touch strobe
    repeat (10) @(posedge clk);
    #1;
    model_deb[0] = model_pad[0];
    model_deb[1] = model_pad[1];
    bus_write(16'h4017, 8'h01);
    bus_read(0, "wr4017_ignored");

    // Reads at an unmapped address produce no rd_valid
    @(posedge clk); #1;
    bus.addr = 16'h4018;
    bus.re   = 1'b1;
    @(posedge clk); #1;
    bus.re   = 1'b0;
    bus.addr = 16'h0000;
    @(negedge clk);
    check("nohit_rd_valid", {31'd0, bus.rd_valid}, 32'd0);

    // Simultaneous read and write: read sees pre-write shift contents
    set_pads(8'h01, 8'h00);
    latch();
    bus_read(0, "rw_first");
    bus_read_write0(0, 8'h01, "rw_same_cycle");
    bus_read(0, "rw_strobed");
    bus_write(16'h4016, 8'h00);
    bus_read(0, "rw_relatch0");
    bus_read(0, "rw_relatch1");
    bus_read_write0(1, 8'h00, "rw_other_port");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
